// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// D-bit ripple-carry cell shared by every digit of a serial operation.
module digit_adder #(
    parameter int D = 2
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    output logic [D-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [D:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < D; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[D];
    assign c_msb_in = c[D-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement add/subtract, LSB digit first,
// with start/busy/done handshake and registered status flags.
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Ovf,
    output logic         Zero
);

    localparam int STEPS = N / D;
    localparam int CW    = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;

    state_t         state;
    logic [N-1:0]   opa;
    logic [N-1:0]   opb;
    logic [N-1:0]   res;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic [D-1:0]   dsum;
    logic           dcout;
    logic           dmsb;
    logic [N-1:0]   res_nx;
    logic           last;

    digit_adder #(.D(D)) u_cell (
        .a        (opa[D-1:0]),
        .b        (opb[D-1:0]),
        .cin      (carry),
        .sum      (dsum),
        .cout     (dcout),
        .c_msb_in (dmsb)
    );

    // New digit enters at the MSB end; also valid when D == N.
    assign res_nx = N'({dsum, res} >> D);
    assign last   = (cnt == CW'(STEPS - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B ^ {N{mode}};
                        carry <= (mode == MODE_SUB);
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    opa   <= opa >> D;
                    opb   <= opb >> D;
                    carry <= dcout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        S     <= res_nx;
                        Cout  <= dcout;
                        Ovf   <= dcout ^ dmsb;
                        Zero  <= (res_nx == '0);
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub at three parametrisations.
module tb_serial_add_sub;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [2:0]  st;
    logic [2:0]  bz, dn, co, ov, zr;
    logic [7:0]  s0;
    logic [15:0] s1;
    logic [7:0]  s2;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_add_sub #(.N(8), .D(2)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .A(a[7:0]), .B(b[7:0]),
        .mode(mode), .busy(bz[0]), .done(dn[0]), .S(s0),
        .Cout(co[0]), .Ovf(ov[0]), .Zero(zr[0])
    );

    serial_add_sub #(.N(16), .D(4)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .A(a), .B(b),
        .mode(mode), .busy(bz[1]), .done(dn[1]), .S(s1),
        .Cout(co[1]), .Ovf(ov[1]), .Zero(zr[1])
    );

    serial_add_sub #(.N(8), .D(8)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .A(a[7:0]), .B(b[7:0]),
        .mode(mode), .busy(bz[2]), .done(dn[2]), .S(s2),
        .Cout(co[2]), .Ovf(ov[2]), .Zero(zr[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int w);
        return (w == 1) ? 16 : 8;
    endfunction

    function automatic int steps_of(input int w);
        return (w == 2) ? 1 : 4;
    endfunction

    // Reference: sign-based overflow, independent of the carry chain.
    function automatic exp_t model(input int n, input logic [15:0] x,
                                   input logic [15:0] y, input logic m);
        exp_t        e;
        logic [16:0] t;
        logic [15:0] mask;
        logic [15:0] xx;
        logic [15:0] yy;
        mask = (n == 16) ? 16'hFFFF : 16'h00FF;
        xx   = x & mask;
        yy   = (y ^ {16{m}}) & mask;
        t    = {1'b0, xx} + {1'b0, yy} + 17'(m);
        e.s  = t[15:0] & mask;
        e.c  = (n == 16) ? t[16] : t[8];
        e.o  = (xx[n-1] == yy[n-1]) && (e.s[n-1] != xx[n-1]);
        e.z  = (e.s == 16'h0);
        return e;
    endfunction

    task automatic sample(input int w, output logic [15:0] s,
                          output logic c, output logic o,
                          output logic z, output logic bs,
                          output logic d);
        case (w)
            0:       s = {8'h00, s0};
            1:       s = s1;
            default: s = {8'h00, s2};
        endcase
        c  = co[w];
        o  = ov[w];
        z  = zr[w];
        bs = bz[w];
        d  = dn[w];
    endtask

    task automatic chk_idle_zero(input int w, input string tag);
        logic [15:0] s;
        logic c, o, z, bs, d;
        sample(w, s, c, o, z, bs, d);
        chk({tag, "_S"}, 32'(s), 32'h0);
        chk({tag, "_flags"}, {28'h0, c, o, z, bs}, 32'h0);
        chk({tag, "_done"}, 32'(d), 32'h0);
    endtask

    // hold=1 keeps start high with A=0x11 through busy and done.
    task automatic run_op(input int w, input logic [15:0] x,
                          input logic [15:0] y, input logic m,
                          input bit hold);
        logic [15:0] s;
        logic c, o, z, bs, d;
        int   nb;
        bit   got;
        exp_t e;
        @(negedge clk);
        a    = x;
        b    = y;
        mode = m;
        st[w] = 1'b1;
        q.push_back(model(width_of(w), x, y, m));
        @(posedge clk);
        #1;
        if (hold) a = 16'h0011;
        else      st[w] = 1'b0;
        nb  = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            sample(w, s, c, o, z, bs, d);
            if (d) got = 1;
            else if (bs) nb++;
        end
        e = q.pop_front();
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout dut=%0d observed=no_done expected=done", w);
        end else begin
            chk("latency", 32'(nb), 32'(steps_of(w)));
            chk("busy_at_done", 32'(bs), 32'h0);
            chk("S", 32'(s), 32'(e.s));
            chk("Cout", 32'(c), 32'(e.c));
            chk("Ovf", 32'(o), 32'(e.o));
            chk("Zero", 32'(z), 32'(e.z));
        end
    endtask

    initial begin
        logic [15:0] s;
        logic c, o, z, bs, d;
        bit   saw;
        rst  = 1'b1;
        st   = '0;
        a    = '0;
        b    = '0;
        mode = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) chk_idle_zero(w, "reset");
        rst = 1'b0;

        // Basic add, then signed overflow and unsigned carry
        run_op(0, 16'h01, 16'h02, 1'b0, 0);
        run_op(0, 16'h7F, 16'h01, 1'b0, 0);
        run_op(0, 16'hFF, 16'hFF, 1'b0, 0);

        // Subtract with borrow, subtract to zero
        run_op(0, 16'h04, 16'h0A, 1'b1, 0);
        run_op(0, 16'hAA, 16'hAA, 1'b1, 0);

        // start held through busy and done must not retrigger
        run_op(0, 16'h89, 16'h03, 1'b1, 1);
        @(negedge clk);
        st[0] = 1'b0;
        sample(0, s, c, o, z, bs, d);
        chk("no_retrigger_busy", 32'(bs), 32'h0);
        chk("no_retrigger_done", 32'(d), 32'h0);
        repeat (3) @(negedge clk);
        sample(0, s, c, o, z, bs, d);
        chk("hold_S", 32'(s), 32'h86);
        chk("hold_Cout", 32'(c), 32'h1);
        chk("idle_busy", 32'(bs), 32'h0);

        // Reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a     = 16'h01;
        b     = 16'h02;
        mode  = 1'b0;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero(0, "abort");
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dn[0]) saw = 1;
        end
        chk("abort_no_done", 32'(saw), 32'h0);
        run_op(0, 16'h10, 16'h20, 1'b0, 0);

        // Random operands on all three parametrisations
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 8; k++) begin
                run_op(w, 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)), 0);
            end
        end

        // Boundary values on the wide and single-digit variants
        run_op(1, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(1, 16'h8000, 16'h0001, 1'b1, 0);
        run_op(2, 16'h0080, 16'h0080, 1'b0, 0);
        run_op(2, 16'h0055, 16'h0055, 1'b1, 0);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
